// File: rtl/vga_capture.sv
// vga_capture: VGA sync receiver; recovers x/y from hsync/vsync, checks line/frame geometry, locks, then strobes wr_en/wr_x/wr_y/wr_data per active pixel (plus frame_start, locked, sync_err, err_count)
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_BACK = 48,
  parameter int H_TOTAL = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_BACK = 33,
  parameter int V_TOTAL = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] color_in,
  output logic       wr_en,
  output logic [9:0] wr_x,
  output logic [9:0] wr_y,
  output logic [7:0] wr_data,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_LO = 10'(H_BACK);
  localparam logic [9:0] H_HI = 10'(H_BACK + H_ACTIVE);
  localparam logic [9:0] V_LO = 10'(V_BACK);
  localparam logic [9:0] V_HI = 10'(V_BACK + V_ACTIVE);
  localparam logic [9:0] V_LINES = 10'(V_TOTAL);
  localparam logic [7:0] LF = 8'(LOCK_FRAMES);
  state_t state, state_nx;
  logic hs_d, vs_d, first_line, frame_bad;
  logic [9:0] h_cnt, v_cnt, lines;
  logic [7:0] good_frames;
  logic hs_rise, vs_rise, checking, line_err, hsat_err, vsat_err, frame_err, err, good_close, capture;
  assign hs_rise = hsync_in & ~hs_d;
  assign vs_rise = vsync_in & ~vs_d;
  assign checking = state != SEARCH;
  assign lines = (hs_rise && v_cnt != 10'd1023) ? v_cnt + 10'd1 : v_cnt;
  assign line_err = checking & hs_rise & ~first_line & (h_cnt != H_LAST);
  assign hsat_err = checking & ~hs_rise & (h_cnt == 10'd1022);
  assign vsat_err = checking & hs_rise & ~vs_rise & (v_cnt == 10'd1022);
  assign frame_err = checking & vs_rise & (lines != V_LINES);
  assign err = line_err | hsat_err | vsat_err | frame_err;
  assign good_close = (state == TRAIN) & vs_rise & ~err & ~frame_bad;
  assign capture = (state == LOCKED) & ~err & (h_cnt >= H_LO) & (h_cnt < H_HI) & (v_cnt >= V_LO) & (v_cnt < V_HI);
  assign locked = state == LOCKED;
  always_comb begin
    state_nx = state;
    if (state == SEARCH) state_nx = vs_rise ? TRAIN : SEARCH;
    else if (state == LOCKED) state_nx = err ? TRAIN : LOCKED;
    else state_nx = (good_close && good_frames + 8'd1 >= LF) ? LOCKED : TRAIN;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= SEARCH;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      h_cnt <= '0;
      v_cnt <= '0;
      good_frames <= '0;
      first_line <= 1'b0;
      frame_bad <= 1'b0;
      wr_en <= 1'b0;
      wr_x <= '0;
      wr_y <= '0;
      wr_data <= '0;
      frame_start <= 1'b0;
      sync_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      hs_d <= hsync_in;
      vs_d <= vsync_in;
      h_cnt <= hs_rise ? '0 : h_cnt + {9'd0, h_cnt != 10'd1023};
      v_cnt <= vs_rise ? '0 : lines;
      first_line <= (state_nx == TRAIN && state != TRAIN) | (first_line & ~hs_rise);
      frame_bad <= ~vs_rise & (frame_bad | err);
      good_frames <= err ? 8'd0 : good_close ? good_frames + 8'd1 : good_frames;
      sync_err <= err;
      err_count <= err_count + {7'd0, err && err_count != 8'hFF};
      wr_en <= capture;
      frame_start <= capture && h_cnt == H_LO && v_cnt == V_LO;
      wr_x <= capture ? h_cnt - H_LO : wr_x;
      wr_y <= capture ? v_cnt - V_LO : wr_y;
      wr_data <= capture ? color_in : wr_data;
    end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: randomized stream bench for vga_capture at reduced geometry with a frame-level reference model
module tb_vga_capture;
  localparam int HA = 16, HB = 4, HT = 32, VA = 6, VB = 3, VT = 12, LF = 2;
  logic clock = 0, reset = 1, hsync_in = 1, vsync_in = 1;
  logic [7:0] color_in = 0;
  logic wr_en, frame_start, locked, sync_err;
  logic [9:0] wr_x, wr_y;
  logic [7:0] wr_data, err_count;
  vga_capture #(.H_ACTIVE(HA), .H_BACK(HB), .H_TOTAL(HT), .V_ACTIVE(VA), .V_BACK(VB), .V_TOTAL(VT), .LOCK_FRAMES(LF)) dut (
    .clock(clock), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .color_in(color_in),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err), .err_count(err_count)
  );
  always #10 clock = ~clock;
  int checks = 0, passed = 0;
  int cmode;
  bit prev_hs, prev_vs;
  bit m_synced, m_skip, m_locked, m_fbad;
  int m_n, m_lines, m_good, m_errs;
  int bad_wr, bad_lk, bad_se, bad_ec, wr_cnt, se_cnt, a5_cnt, a5_x, a5_y;
  int fx, fy, ffs, lx, ly;
  bit se_lk;
  bit lk_q[$];
  function automatic int lk_bits();
    int v = 0;
    foreach (lk_q[i]) v = v * 2 + int'(lk_q[i]);
    return v;
  endfunction
  task automatic clr_stats();
    bad_wr = 0; bad_lk = 0; bad_se = 0; bad_ec = 0; wr_cnt = 0; se_cnt = 0; a5_cnt = 0;
    a5_x = -1; a5_y = -1; fx = -1; fy = -1; ffs = -1; lx = -1; ly = -1; se_lk = 1;
    lk_q.delete();
  endtask
  task automatic do_reset();
    reset = 1; hsync_in = 1; vsync_in = 1; color_in = 0; prev_hs = 1; prev_vs = 1;
    m_synced = 0; m_skip = 0; m_locked = 0; m_fbad = 0; m_n = 1; m_lines = 0; m_good = 0; m_errs = 0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
  endtask
  task automatic drive_cycle(input bit hs, input bit vs, input logic [7:0] col, input bit act, input int x, input int y);
    bit he, ve, e, exp_wr, exp_fs;
    he = hs & !prev_hs;
    ve = vs & !prev_vs;
    e = 0;
    if (m_synced && he && !m_skip && m_n != HT) e = 1;
    if (m_synced && !he && m_n == 1023) e = 1;
    if (he) m_skip = 0;
    if (m_synced && ve && (he ? m_lines + 1 : m_lines) != VT) e = 1;
    if (e) begin
      m_errs++; m_good = 0;
      if (m_locked) m_skip = 1;
      m_locked = 0;
    end
    if (ve) begin
      if (!m_synced) begin m_synced = 1; m_skip = 1; end
      else if (!m_fbad && !e) begin m_good++; if (m_good >= LF) m_locked = 1; end
      m_fbad = 0; m_lines = 0;
    end else begin
      m_fbad |= e;
      if (he) m_lines++;
    end
    m_n = he ? 1 : m_n + 1;
    exp_wr = m_locked && act;
    exp_fs = exp_wr && x == 0 && y == 0;
    hsync_in = hs; vsync_in = vs; color_in = col; prev_hs = hs; prev_vs = vs;
    @(posedge clock);
    #1;
    if (wr_en !== exp_wr || frame_start !== exp_fs) bad_wr++;
    else if (exp_wr && (wr_x !== 10'(x) || wr_y !== 10'(y) || wr_data !== col)) bad_wr++;
    if (wr_en === 1'b1) begin
      if (wr_cnt == 0) begin fx = int'(wr_x); fy = int'(wr_y); ffs = int'(frame_start); end
      wr_cnt++; lx = int'(wr_x); ly = int'(wr_y);
      if (wr_data === 8'hA5) begin a5_cnt++; a5_x = int'(wr_x); a5_y = int'(wr_y); end
    end
    if (locked !== m_locked) bad_lk++;
    if (sync_err !== e) bad_se++;
    if (err_count !== 8'(m_errs > 255 ? 255 : m_errs)) bad_ec++;
    if (sync_err === 1'b1) begin se_cnt++; se_lk = locked; end
    if (ve) lk_q.push_back(locked);
  endtask
  task automatic send_line(input int l, input int nl, input int len, input bit hold, input int stop);
    for (int p = 0; p < stop; p++) begin
      bit hs, vs, act;
      logic [7:0] c;
      hs = hold || p < len - 4;
      vs = l < nl - 2;
      act = p >= HB + 1 && p <= HB + HA && l >= VB && l < VB + VA;
      c = cmode == 0 ? 8'($urandom) : cmode == 1 ? 8'((p + HT - 1) % HT) : (p == HB + 1 && l == VB) ? 8'hA5 : 8'h00;
      drive_cycle(hs, vs, c, act, p - HB - 1, l - VB);
    end
  endtask
  task automatic send_frame(input int nl, input int short_l, input int stop_l);
    for (int l = 0; l < nl; l++) begin
      if (l == stop_l) begin
        send_line(l, nl, HT, 0, HB + 8);
        return;
      end
      send_line(l, nl, l == short_l ? HT - 1 : HT, 0, l == short_l ? HT - 1 : HT);
    end
  endtask
  task automatic test_reset();
    reset = 1;
    #1;
    checks++; if ({wr_en, frame_start, locked, sync_err} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {wr_en, frame_start, locked, sync_err}); else passed++;
    checks++; if ({wr_x, wr_y, wr_data, err_count} !== 36'b0) $display("FAIL reset_data: got %h want 0", {wr_x, wr_y, wr_data, err_count}); else passed++;
    do_reset();
  endtask
  task automatic test_nominal();
    do_reset(); clr_stats(); cmode = 1;
    repeat (4) send_frame(VT, -1, -1);
    checks++; if (lk_q.size() != 3 || lk_bits() != 1) $display("FAIL nom_lock: got n=%0d bits=%0d want n=3 bits=1", lk_q.size(), lk_bits()); else passed++;
    checks++; if (wr_cnt != HA * VA) $display("FAIL nom_count: got %0d want %0d", wr_cnt, HA * VA); else passed++;
    checks++; if (fx != 0 || fy != 0 || ffs != 1) $display("FAIL nom_first: got (%0d,%0d) fs=%0d want (0,0) fs=1", fx, fy, ffs); else passed++;
    checks++; if (lx != HA - 1 || ly != VA - 1) $display("FAIL nom_last: got (%0d,%0d) want (%0d,%0d)", lx, ly, HA - 1, VA - 1); else passed++;
    checks++; if (se_cnt != 0) $display("FAIL nom_sync_err: got %0d want 0", se_cnt); else passed++;
    checks++; if (bad_wr != 0 || bad_lk != 0 || bad_se != 0 || bad_ec != 0) $display("FAIL nom_model: got wr=%0d lk=%0d se=%0d ec=%0d want 0", bad_wr, bad_lk, bad_se, bad_ec); else passed++;
  endtask
  task automatic test_align();
    do_reset(); clr_stats(); cmode = 2;
    repeat (4) send_frame(VT, -1, -1);
    checks++; if (a5_cnt != 1 || a5_x != 0 || a5_y != 0) $display("FAIL align_a5: got n=%0d at (%0d,%0d) want n=1 at (0,0)", a5_cnt, a5_x, a5_y); else passed++;
    checks++; if (bad_wr != 0) $display("FAIL align_model: got %0d write mismatches want 0", bad_wr); else passed++;
  endtask
  task automatic test_short_line();
    int w0;
    do_reset(); clr_stats(); cmode = 0;
    repeat (3) send_frame(VT, -1, -1);
    send_frame(VT, VB + 1, -1);
    w0 = wr_cnt;
    repeat (2) send_frame(VT, -1, -1);
    checks++; if (wr_cnt != w0) $display("FAIL short_quiet: got %0d writes want 0", wr_cnt - w0); else passed++;
    send_frame(VT, -1, -1);
    checks++; if (se_cnt != 1 || se_lk != 0) $display("FAIL short_err: got pulses=%0d locked=%0d want 1/0", se_cnt, se_lk); else passed++;
    checks++; if (err_count !== 8'd1) $display("FAIL short_count: got %0d want 1", err_count); else passed++;
    checks++; if (lk_q.size() != 6 || lk_bits() != 9) $display("FAIL short_relock: got n=%0d bits=%0d want n=6 bits=9", lk_q.size(), lk_bits()); else passed++;
    checks++; if (wr_cnt != w0 + HA * VA) $display("FAIL short_resume: got %0d want %0d", wr_cnt, w0 + HA * VA); else passed++;
    checks++; if (bad_wr != 0 || bad_lk != 0 || bad_se != 0 || bad_ec != 0) $display("FAIL short_model: got wr=%0d lk=%0d se=%0d ec=%0d want 0", bad_wr, bad_lk, bad_se, bad_ec); else passed++;
  endtask
  task automatic test_hold();
    do_reset(); clr_stats(); cmode = 0;
    repeat (3) send_frame(VT, -1, -1);
    for (int l = 0; l < VB + 2; l++) send_line(l, VT, HT, 0, HT);
    send_line(VB + 2, VT, 3100, 1, 3100);
    checks++; if (se_cnt != 1) $display("FAIL hold_pulses: got %0d want 1", se_cnt); else passed++;
    checks++; if (err_count !== 8'd1 || locked !== 1'b0) $display("FAIL hold_state: got cnt=%0d locked=%0d want 1/0", err_count, locked); else passed++;
    checks++; if (bad_wr != 0 || bad_lk != 0 || bad_se != 0 || bad_ec != 0) $display("FAIL hold_model: got wr=%0d lk=%0d se=%0d ec=%0d want 0", bad_wr, bad_lk, bad_se, bad_ec); else passed++;
  endtask
  task automatic test_short_frame();
    do_reset(); clr_stats(); cmode = 0;
    send_frame(VT, -1, -1);
    send_frame(VT - 1, -1, -1);
    repeat (3) send_frame(VT, -1, -1);
    checks++; if (se_cnt != 1 || err_count !== 8'd1) $display("FAIL frame_err: got pulses=%0d cnt=%0d want 1/1", se_cnt, err_count); else passed++;
    checks++; if (lk_q.size() != 4 || lk_bits() != 1) $display("FAIL frame_lock: got n=%0d bits=%0d want n=4 bits=1", lk_q.size(), lk_bits()); else passed++;
    checks++; if (wr_cnt != HA * VA || bad_wr != 0 || bad_lk != 0 || bad_se != 0) $display("FAIL frame_model: got writes=%0d wr=%0d lk=%0d se=%0d want %0d/0/0/0", wr_cnt, bad_wr, bad_lk, bad_se, HA * VA); else passed++;
  endtask
  task automatic test_reset_mid();
    int w3;
    do_reset(); clr_stats(); cmode = 0;
    repeat (3) send_frame(VT, -1, -1);
    send_frame(VT, 0, -1);
    repeat (2) send_frame(VT, -1, -1);
    send_frame(VT, -1, VB);
    checks++; if (wr_en !== 1'b1 || locked !== 1'b1 || err_count !== 8'd1) $display("FAIL mid_pre: got wr=%0d locked=%0d cnt=%0d want 1/1/1", wr_en, locked, err_count); else passed++;
    #5 reset = 1;
    #1;
    checks++; if (wr_en !== 1'b0 || locked !== 1'b0 || err_count !== 8'd0) $display("FAIL mid_async: got wr=%0d locked=%0d cnt=%0d want 0/0/0", wr_en, locked, err_count); else passed++;
    do_reset(); clr_stats();
    repeat (3) send_frame(VT, -1, -1);
    w3 = wr_cnt;
    send_frame(VT, -1, -1);
    checks++; if (w3 != 0) $display("FAIL mid_early: got %0d writes want 0", w3); else passed++;
    checks++; if (lk_q.size() != 3 || lk_bits() != 1 || wr_cnt != HA * VA) $display("FAIL mid_relock: got n=%0d bits=%0d writes=%0d want 3/1/%0d", lk_q.size(), lk_bits(), wr_cnt, HA * VA); else passed++;
    checks++; if (bad_wr != 0 || bad_lk != 0 || bad_se != 0 || bad_ec != 0) $display("FAIL mid_model: got wr=%0d lk=%0d se=%0d ec=%0d want 0", bad_wr, bad_lk, bad_se, bad_ec); else passed++;
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_nominal();
    test_align();
    test_short_line();
    test_hold();
    test_short_frame();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the on-chip 640x480@60 VGA timing generator. Runs on the same 25 MHz pixel clock.
- Consumes active-low hsync/vsync and 8-bit RRRGGGBB pixel data, and recovers pixel coordinates from the sync edges.
- Checks line and frame geometry and declares lock.
- When locked, emits one write strobe per active pixel, with (x, y, data), toward a framebuffer writer.
- Used for loopback self-test of the video path and for capturing video from an external source.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_BACK, 48, clocks from hsync rising edge (detection cycle = count 0) to first active pixel
- H_TOTAL, 800, required clocks between consecutive hsync rising edges
- V_ACTIVE, 480, active lines per frame
- V_BACK, 33, hsync rising edges after vsync rising edge before first active line
- V_TOTAL, 525, required hsync rising edges between consecutive vsync rising edges
- LOCK_FRAMES, 2, consecutive good frames needed to lock

Ports:
- clock  in  1  pixel clock, 25 MHz
- reset  in  1  reset, asynchronous, active-high
- hsync_in  in  1  horizontal sync, active low, synchronous to clock
- vsync_in  in  1  vertical sync, active low, synchronous to clock
- color_in  in  8  pixel data (RRRGGGBB)
- wr_en  out  1  one-cycle strobe per captured active pixel
- wr_x  out  10  pixel column 0..H_ACTIVE-1
- wr_y  out  10  pixel row 0..V_ACTIVE-1
- wr_data  out  8  captured pixel
- frame_start  out  1  pulse coincident with wr_en at x=0, y=0
- locked  out  1  geometry lock indicator
- sync_err  out  1  one-cycle pulse per detected geometry error
- err_count  out  8  saturating count of sync_err pulses

Behaviour:
- Reset state: all outputs 0; state=SEARCH; h_cnt=0; v_cnt=0; good_frames=0; hs_d=1; vs_d=1.
- Edge detection:
  - hs_d and vs_d register the previous cycle's inputs.
  - hs_rise = hsync_in & ~hs_d; vs_rise = vsync_in & ~vs_d.
- h_cnt (10 b):
  - Loads 0 on hs_rise, else increments.
  - Saturates at 1023.
- v_cnt (10 b):
  - On hs_rise, increments, saturating at 1023.
  - On vs_rise, loads 0.
  - If both occur in the same cycle, the hsync edge is counted toward the ending frame's total first, then v_cnt loads 0.
- Line check, states TRAIN/LOCKED only:
  - On hs_rise, error if the pre-load h_cnt+1 != H_TOTAL.
  - The first hs_rise after entering TRAIN is not checked.
  - h_cnt reaching 1023 is a single error (hsync lost); it is not repeated while saturated.
- Frame check, on vs_rise in TRAIN/LOCKED: error if the frame's hsync-rise count != V_TOTAL. A v_cnt of 1023 is also an error, flagged once.
- Error effects:
  - sync_err pulses for one cycle, even when line and frame errors coincide.
  - err_count increments, saturating at 255.
  - good_frames clears to 0; a frame containing any error is not good.
- States:
  - SEARCH: wait for vs_rise, then go to TRAIN.
  - TRAIN: on vs_rise closing an error-free frame, good_frames increments. If it reaches LOCK_FRAMES, go to LOCKED and assert locked in the same cycle as the state change.
  - LOCKED: any error, in the cycle it is detected, goes to TRAIN; locked falls in that same cycle.
- Capture:
  - Condition: state==LOCKED, V_BACK <= v_cnt < V_BACK+V_ACTIVE, and H_BACK <= h_cnt < H_BACK+H_ACTIVE, all evaluated on the current cycle's h_cnt/v_cnt.
  - Next cycle: wr_en=1, wr_x=h_cnt-H_BACK, wr_y=v_cnt-V_BACK, wr_data=color_in. Latency is one cycle.
  - wr_x/wr_y/wr_data hold their last values when wr_en=0.
  - If an error drops lock mid-line, no further strobes are issued from the following cycle onward.
- Reset mid-frame takes effect immediately (asynchronous): outputs clear and the block restarts at SEARCH.

Test Plan:
- Nominal 640x480 stream, 4 frames, color_in=h position[7:0] -> locked rises at the 3rd vsync rising edge; frame 4 yields exactly 307200 wr_en pulses; first write wr_x=0, wr_y=0 with frame_start=1; last write wr_x=639, wr_y=479; sync_err never asserts.
- Pixel alignment: color_in=8'hA5 only at h_cnt=48 on line v_cnt=33, else 0 -> exactly one write with wr_data=8'hA5 at (0,0), one cycle later.
- Locked stream, one line shortened to 799 clocks -> sync_err one pulse; locked=0 the same cycle; err_count=1; no strobes until relock 2 frames later.
- hsync held high after lock -> sync_err once when h_cnt saturates; err_count=1; locked=0; err_count still 1 after 2000 further cycles.
- Frame with 524 lines during TRAIN -> sync_err at its closing vs_rise; good_frames reset; lock delayed by one extra frame.
- Reset asserted mid-active-line while locked -> wr_en, locked, err_count read 0 asynchronously; after release, no writes before 3 vsync rising edges.
